// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: CPU clock-enable generator with run/halt, debounced single-step and prescaled run rate.
// Latency: run_sw reaches the FSM after 2 synchronizer cycles; step_btn needs 2 + DB_COUNT stable cycles.
// Optional macro CYCLE_COUNT_EN adds the 32-bit cycle_count output; halt_req always wins over a run tick.
module cpu_clk_ctrl #(
    parameter int DB_COUNT = 50000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic [1:0]  div_sel,
    output logic        cpu_ce,
    output logic        running
`ifdef CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_count
`endif
);

    localparam logic [1:0]  S_HALTED  = 2'd0;
    localparam logic [1:0]  S_RUNNING = 2'd1;
    localparam logic [1:0]  S_STEP    = 2'd2;
    localparam logic [15:0] DB_LAST   = 16'(DB_COUNT - 1);

    logic        r_run_meta;
    logic        r_run_s;
    logic        r_step_meta;
    logic        r_step_s;
    logic [15:0] r_db_cnt;
    logic        r_step_stable;
    logic        r_step_stable_d;
    logic [7:0]  r_pre_cnt;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  w_mask;
    logic        w_tick;
    logic        w_step_req;
    logic        w_cpu_ce;

    // Two-flop synchronizers for the asynchronous switch and button
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_step_meta <= 1'b0;
            r_step_s    <= 1'b0;
        end else begin
            r_run_meta  <= run_sw;
            r_run_s     <= r_run_meta;
            r_step_meta <= step_btn;
            r_step_s    <= r_step_meta;
        end
    end

    // Debounce: accept a new button level only after DB_COUNT consecutive differing cycles
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_db_cnt        <= 16'd0;
            r_step_stable   <= 1'b0;
            r_step_stable_d <= 1'b0;
        end else begin
            r_step_stable_d <= r_step_stable;
            if (r_step_s == r_step_stable) begin
                r_db_cnt <= 16'd0;
            end else if (r_db_cnt == DB_LAST) begin
                r_step_stable <= r_step_s;
                r_db_cnt      <= 16'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 16'd1;
            end
        end
    end

    // Press only (rising edge of the debounced level) requests a step
    assign w_step_req = r_step_stable & ~r_step_stable_d;

    // Free-running prescaler; div_sel is never allowed to reset it
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= 8'd0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 8'd1;
        end
    end

    // Rate mask: tick fires when all masked prescaler bits are ones
    always_comb begin
        w_mask = 8'h00;
        case (div_sel)
            2'd0:    w_mask = 8'h00;
            2'd1:    w_mask = 8'h03;
            2'd2:    w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_tick = ((r_pre_cnt & w_mask) == w_mask);

    // Next state: run beats a coincident step; a step is allowed even while halt_req is high
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALTED: begin
                if (r_run_s && !halt_req) begin
                    w_state_nxt = S_RUNNING;
                end else if (w_step_req) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUNNING: begin
                if (halt_req || !r_run_s) begin
                    w_state_nxt = S_HALTED;
                end
            end
            default: w_state_nxt = S_HALTED;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enable is combinational from state so an async reset kills it immediately
    assign w_cpu_ce = (r_state == S_STEP) ||
                      ((r_state == S_RUNNING) && w_tick && !halt_req);
    assign cpu_ce   = w_cpu_ce;
    assign running  = (r_state == S_RUNNING);

`ifdef CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    // Count issued enables, wrapping naturally at 2^32
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cycle_count <= 32'd0;
        end else if (w_cpu_ce) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DB_COUNT, default 50000, debounce stable-cycle count for step_btn (range 2..65535).
REQ-002 clk_in  input  1  sole clock, all logic posedge clk_in.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run_sw  input  1  asynchronous run/halt switch level, 1 = run.
REQ-005 step_btn  input  1  asynchronous, bouncy single-step push button, 1 = pressed.
REQ-006 halt_req  input  1  synchronous halt request from the CPU core, level.
REQ-007 div_sel  input  2  run-rate select: 0 = every cycle, 1 = 1/4, 2 = 1/16, 3 = 1/256.
REQ-008 cpu_ce  output  1  CPU clock-enable, one-cycle pulses in the clk_in domain.
REQ-009 running  output  1  high while the FSM is in RUNNING.
REQ-010 cycle_count  output  32  count of cpu_ce pulses issued (present only with CYCLE_COUNT_EN).

Function
REQ-011 run_sw and step_btn SHALL each pass through a 2-flop synchronizer (run_s, step_s), 2-cycle latency.
REQ-012 Debounce: 16-bit counter SHALL increment each cycle step_s differs from step_stable, clear when equal; on reaching DB_COUNT-1, step_stable SHALL take step_s and the counter SHALL clear.
REQ-013 step_req SHALL pulse exactly one cycle on each 0->1 transition of step_stable; 1->0 SHALL produce nothing.
REQ-014 Prescaler: 8-bit free-running pre_cnt, wraps 255->0; tick = (pre_cnt AND mask) == mask, mask = 0x00/0x03/0x0F/0xFF for div_sel 0/1/2/3.
REQ-015 A div_sel change SHALL take effect on the next cycle without resetting pre_cnt.
REQ-016 FSM states HALTED, RUNNING, STEP; encoding free.
REQ-017 HALTED: run_s=1 and halt_req=0 -> RUNNING; else step_req=1 -> STEP; else stay.
REQ-018 RUNNING: halt_req=1 or run_s=0 -> HALTED; else stay; step_req ignored.
REQ-019 STEP: unconditionally -> HALTED after exactly one cycle.
REQ-020 cpu_ce SHALL be (state==STEP) OR (state==RUNNING AND tick AND NOT halt_req); halt_req wins over a coincident tick.
REQ-021 halt_req high in HALTED SHALL NOT block STEP (single-step past a halt allowed).
REQ-022 Simultaneous run_s=1 and step_req in HALTED: RUNNING wins; the step press is discarded.
REQ-023 running SHALL equal (state==RUNNING), combinational from state.

Reset
REQ-024 rst SHALL asynchronously force: state HALTED, synchronizer flops 0, step_stable 0, debounce counter 0, pre_cnt 0, cycle_count 0.
REQ-025 During and immediately after reset, cpu_ce=0 and running=0; a button held through reset SHALL yield a step only after a full debounce following release-and-press or, if held, after DB_COUNT cycles of stable 1.
REQ-026 rst asserted mid-STEP or mid-RUNNING SHALL suppress any further cpu_ce pulse that cycle.

Configuration
REQ-027 Macro CYCLE_COUNT_EN defined: cycle_count port exists, increments by 1 on every cycle with cpu_ce=1, wraps 0xFFFFFFFF->0.
REQ-028 Macro CYCLE_COUNT_EN undefined: cycle_count port and counter SHALL be absent; all other behaviour identical.

Verification (DB_COUNT=4)
REQ-029 rst pulse, run_sw=0, step_btn=0 -> cpu_ce=0, running=0, cycle_count=0 for 100 cycles.
REQ-030 run_sw=1, div_sel=1, halt_req=0 -> running rises 3 cycles later; cpu_ce pulses once every 4 cycles; cycle_count=25 after 100 pulses-window of 100 cycles steady state.
REQ-031 In HALTED, step_btn bounces 1/0/1 at 1-cycle spacing then holds 1 for 20 cycles -> exactly one cpu_ce pulse, state returns HALTED next cycle.
REQ-032 RUNNING div_sel=0, halt_req=1 asserted coincident with tick -> no cpu_ce that cycle, running=0 next cycle; subsequent clean step press -> one cpu_ce despite halt_req=1.
REQ-033 Preload cycle_count 0xFFFFFFFF via force, one step -> cycle_count=0 (CYCLE_COUNT_EN build); same bench compiles without the macro and passes REQ-029..032.
REQ-034 rst asserted asynchronously mid-RUNNING between clock edges -> cpu_ce and running drop immediately, all counters 0.
